// File: rtl/st_packets_to_bytes_encoder_pkg.sv
// Shared constants, FSM state type and reserved-byte test for the
// Avalon-ST packet to byte-stream encoder.
package st_bytes_pkg;

  localparam logic [7:0] SOP     = 8'h7A;
  localparam logic [7:0] EOP     = 8'h7B;
  localparam logic [7:0] CHAN    = 8'h7C;
  localparam logic [7:0] ESC     = 8'h7D;
  localparam logic [7:0] ESC_XOR = 8'h20;

  // Each state names the byte currently presented on out_data.
  typedef enum logic [2:0] {
    IDLE,
    CHAN_MK,
    CHAN_ESC,
    CHAN_VAL,
    SOP_MK,
    EOP_MK,
    DATA_ESC,
    DATA
  } state_t;

  function automatic logic is_reserved(input logic [7:0] b);
    return (b >= SOP) && (b <= ESC);
  endfunction

endpackage

// File: rtl/st_packets_to_bytes_encoder_if.sv
// Input packet stream and output byte stream of the encoder, bundled
// so the encoder and its environment connect through one port.
interface st_packets_to_bytes_encoder_if #(
  parameter int CHANNEL_WIDTH = 8
);

  logic                     in_ready;
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     in_startofpacket;
  logic                     in_endofpacket;
  logic [CHANNEL_WIDTH-1:0] in_channel;
  logic                     out_ready;
  logic                     out_valid;
  logic [7:0]               out_data;

  modport master (
    input  in_ready,
    output in_valid, in_data, in_startofpacket, in_endofpacket, in_channel,
    output out_ready,
    input  out_valid, out_data
  );

  modport slave (
    output in_ready,
    input  in_valid, in_data, in_startofpacket, in_endofpacket, in_channel,
    input  out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/st_packets_to_bytes_encoder_escaper.sv
// Combinational escaper: flags a reserved byte and supplies the value that
// follows the ESC marker on the wire.
module st_byte_escaper
  import st_bytes_pkg::*;
(
  input  logic [7:0] din,
  output logic       need_esc,
  output logic [7:0] dout
);

  assign need_esc = is_reserved(din);
  assign dout     = need_esc ? (din ^ ESC_XOR) : din;

endmodule

// File: rtl/st_packets_to_bytes_encoder.sv
// Serialises an Avalon-ST packet stream into a byte stream with in-band
// channel, SOP/EOP markers and escaping of reserved values.
//
// state    | meaning
// IDLE     | nothing presented, ready for a new beat
// CHAN_MK  | presenting channel marker 0x7C
// CHAN_ESC | presenting ESC before a reserved channel value
// CHAN_VAL | presenting the (possibly escaped) channel value
// SOP_MK   | presenting start-of-packet marker 0x7A
// EOP_MK   | presenting end-of-packet marker 0x7B
// DATA_ESC | presenting ESC before a reserved data byte
// DATA     | presenting the (possibly escaped) data byte
module st_packets_to_bytes_encoder
  import st_bytes_pkg::*;
#(
  parameter int CHANNEL_WIDTH  = 8,
  parameter int ENCODE_CHANNEL = 1
) (
  input logic                         clk,
  input logic                         reset_n,
  st_packets_to_bytes_encoder_if.slave bus
);

  state_t     state, state_nxt, first_state;
  logic [7:0] h_data, h_chan, last_chan;
  logic       h_sop, h_eop, chan_valid;
  logic [7:0] in_chan_ext;
  logic [7:0] n_data, n_chan;
  logic       n_sop, n_eop;
  logic       accept, xfer, need_chan;
  logic       chan_esc, data_esc;
  logic [7:0] chan_enc, data_enc;
  logic [7:0] out_byte;

  always_comb begin
    in_chan_ext                    = '0;
    in_chan_ext[CHANNEL_WIDTH-1:0] = bus.in_channel;
  end

  assign bus.in_ready = reset_n && ((state == IDLE) || ((state == DATA) && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = bus.out_valid && bus.out_ready;

  // Beat that will sit in the hold register after this edge; lets the first
  // byte of a freshly accepted beat be registered in the same cycle.
  assign n_data = accept ? bus.in_data          : h_data;
  assign n_chan = accept ? in_chan_ext          : h_chan;
  assign n_sop  = accept ? bus.in_startofpacket : h_sop;
  assign n_eop  = accept ? bus.in_endofpacket   : h_eop;

  assign need_chan = (ENCODE_CHANNEL != 0) && n_sop && (!chan_valid || (n_chan != last_chan));

  st_byte_escaper u_chan_esc (
    .din      (n_chan),
    .need_esc (chan_esc),
    .dout     (chan_enc)
  );

  st_byte_escaper u_data_esc (
    .din      (n_data),
    .need_esc (data_esc),
    .dout     (data_enc)
  );

  always_comb begin
    if (need_chan)     first_state = CHAN_MK;
    else if (n_sop)    first_state = SOP_MK;
    else if (n_eop)    first_state = EOP_MK;
    else if (data_esc) first_state = DATA_ESC;
    else               first_state = DATA;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 8'h00;
      h_data        <= 8'h00;
      h_chan        <= 8'h00;
      h_sop         <= 1'b0;
      h_eop         <= 1'b0;
      chan_valid    <= 1'b0;
      last_chan     <= 8'h00;
    end else begin
      state         <= state_nxt;
      bus.out_valid <= (state_nxt != IDLE);
      bus.out_data  <= out_byte;
      if (accept) begin
        h_data <= bus.in_data;
        h_chan <= in_chan_ext;
        h_sop  <= bus.in_startofpacket;
        h_eop  <= bus.in_endofpacket;
      end
      if ((state == CHAN_VAL) && xfer) begin
        last_chan  <= h_chan;
        chan_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = first_state;
      CHAN_MK:  if (xfer) state_nxt = chan_esc ? CHAN_ESC : CHAN_VAL;
      CHAN_ESC: if (xfer) state_nxt = CHAN_VAL;
      CHAN_VAL: if (xfer) state_nxt = SOP_MK;
      SOP_MK: begin
        if (xfer) begin
          if (n_eop)         state_nxt = EOP_MK;
          else if (data_esc) state_nxt = DATA_ESC;
          else               state_nxt = DATA;
        end
      end
      EOP_MK:   if (xfer) state_nxt = data_esc ? DATA_ESC : DATA;
      DATA_ESC: if (xfer) state_nxt = DATA;
      DATA:     if (xfer) state_nxt = accept ? first_state : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_byte = 8'h00;
    case (state_nxt)
      CHAN_MK:  out_byte = CHAN;
      CHAN_ESC: out_byte = ESC;
      CHAN_VAL: out_byte = chan_enc;
      SOP_MK:   out_byte = SOP;
      EOP_MK:   out_byte = EOP;
      DATA_ESC: out_byte = ESC;
      DATA:     out_byte = data_enc;
      default:  out_byte = 8'h00;
    endcase
  end

endmodule
